// File: rtl/mskand_pkg.sv
// rtl/mskand_pkg.sv - shared helpers for masked AND gadgets (randomness sizing, pair index, share layout)
package mskand_pkg;

    // Fresh random bits one lane needs per operation: one per unordered share pair.
    function automatic int hpc2rnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Bit within a lane's randomness slice used by share pair (i,j); symmetric in i and j.
    // The diagonal has no random bit and returns 0 so callers can index safely.
    function automatic int rnd_index(input int i, input int j, input int d);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        if (lo == hi) begin
            return 0;
        end
        return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
    endfunction

    // Share-major bus layout: share s of lane k sits at bit s*w+k.
    function automatic int sm_index(input int s, input int k, input int w);
        return s * w + k;
    endfunction

endpackage

// File: rtl/mskand_hpc2_lane.sv
// rtl/mskand_hpc2_lane.sv - one lane of the HPC2 masked AND datapath, two register stages, no reset
module mskand_hpc2_lane
    import mskand_pkg::*;
#(
    parameter int d = 2,
    localparam int RND_LANE = hpc2rnd(d)
) (
    input  logic                clk,
    input  logic                ld1,
    input  logic                ld2,
    input  logic [d-1:0]        a,
    input  logic [d-1:0]        b,
    input  logic [RND_LANE-1:0] r,
    output logic [d-1:0]        o
);

    // Full d x d matrices; diagonal entries are held at zero so they add nothing to a share.
    logic [d-1:0][d-1:0] v_d, v_q, rh_d, rh_q, u_d, u_q, w_d, w_q;
    logic [d-1:0]        a1_d, a1_q, b1_d, b1_q, t_d, t_q;

    // Stage-1 next values: refresh b_j with r[i][j] and keep a copy of r[i][j] with the op.
    always_comb begin
        a1_d = a;
        b1_d = b;
        v_d  = '0;
        rh_d = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i != j) begin
                    rh_d[i][j] = r[rnd_index(i, j, d)];
                    v_d[i][j]  = b[j] ^ r[rnd_index(i, j, d)];
                end
            end
        end
    end

    // Stage-2 next values: each term depends on a single share of a, nothing mixed across shares.
    always_comb begin
        t_d = a1_q & b1_q;
        u_d = '0;
        w_d = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                u_d[i][j] = ~a1_q[i] & rh_q[i][j];
                w_d[i][j] =  a1_q[i] & v_q[i][j];
            end
        end
    end

    // Stage-1 data registers load only when the pipeline accepts a new op.
    always_ff @(posedge clk) begin
        if (ld1) begin
            a1_q <= a1_d;
            b1_q <= b1_d;
            v_q  <= v_d;
            rh_q <= rh_d;
        end
    end

    // Stage-2 data registers load only when stage 1 advances.
    always_ff @(posedge clk) begin
        if (ld2) begin
            t_q <= t_d;
            u_q <= u_d;
            w_q <= w_d;
        end
    end

    // Output share i: u and w are exclusive in a1_i, so OR acts as XOR of the two products.
    always_comb begin
        o = t_q;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                o[i] = o[i] ^ (u_q[i][j] | w_q[i][j]);
            end
        end
    end

endmodule

// File: rtl/mskand_hpc2_pipe.sv
// rtl/mskand_hpc2_pipe.sv - W-lane d-share HPC2 masked AND with 2-stage valid/ready pipeline; option MSKAND_HPC2_RNDCNT_EN adds rnd_cnt
module mskand_hpc2_pipe
    import mskand_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 8,
    localparam int RND_LANE = hpc2rnd(d),
    localparam int RND_W = W * RND_LANE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [d*W-1:0]   ina,
    input  logic [d*W-1:0]   inb,
    input  logic [RND_W-1:0] rnd,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [d*W-1:0]   out
`ifdef MSKAND_HPC2_RNDCNT_EN
    ,
    output logic [31:0]      rnd_cnt
`endif
);

    logic v1_d, v1_q, v2_d, v2_q;
    logic acc, adv2;

    logic [W-1:0][d-1:0]        a_l, b_l, o_l;
    logic [W-1:0][RND_LANE-1:0] r_l;

    // Handshake and occupancy: stage 1 frees up when it is empty or moving into stage 2.
    always_comb begin
        adv2      = v1_q & (~v2_q | out_ready);
        in_ready  = ~v1_q | adv2;
        rnd_ready = in_valid & in_ready;
        acc       = in_valid & rnd_valid & in_ready;
        v1_d      = acc | (v1_q & ~adv2);
        v2_d      = adv2 | (v2_q & ~out_ready);
        out_valid = v2_q;
    end

    // Only the valid bits are reset; the data path is don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // Regroup share-major buses into per-lane share vectors and randomness slices.
    always_comb begin
        a_l = '0;
        b_l = '0;
        r_l = '0;
        for (int k = 0; k < W; k++) begin
            for (int s = 0; s < d; s++) begin
                a_l[k][s] = ina[sm_index(s, k, W)];
                b_l[k][s] = inb[sm_index(s, k, W)];
            end
            r_l[k] = rnd[k*RND_LANE +: RND_LANE];
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_lane
        mskand_hpc2_lane #(.d(d)) u_lane (
            .clk (clk),
            .ld1 (acc),
            .ld2 (adv2),
            .a   (a_l[k]),
            .b   (b_l[k]),
            .r   (r_l[k]),
            .o   (o_l[k])
        );
    end

    // Scatter per-lane result shares back into the share-major output bus.
    always_comb begin
        out = '0;
        for (int k = 0; k < W; k++) begin
            for (int s = 0; s < d; s++) begin
                out[sm_index(s, k, W)] = o_l[k][s];
            end
        end
    end

`ifdef MSKAND_HPC2_RNDCNT_EN
    localparam logic [31:0] CNT_STEP = 32'(RND_W);
    logic [31:0] rnd_cnt_d, rnd_cnt_q;

    // Consumed-randomness counter, sticking at all-ones instead of wrapping.
    always_comb begin
        rnd_cnt_d = rnd_cnt_q;
        if (acc) begin
            rnd_cnt_d = (rnd_cnt_q > (32'hFFFF_FFFF - CNT_STEP)) ? 32'hFFFF_FFFF
                                                                 : rnd_cnt_q + CNT_STEP;
        end
    end

    // Counter register, cleared with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_cnt_q <= '0;
        end else begin
            rnd_cnt_q <= rnd_cnt_d;
        end
    end

    assign rnd_cnt = rnd_cnt_q;
`endif

endmodule

// File: tb/tb_mskand_hpc2_pipe.sv
// tb/tb_mskand_hpc2_pipe.sv - scoreboard bench for mskand_hpc2_pipe at d=3, W=8 (MSKAND_HPC2_RNDCNT_EN optional)
module tb_mskand_hpc2_pipe;

    localparam int D  = 3;
    localparam int W  = 8;
    localparam int RW = W * D * (D - 1) / 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           rnd_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic           in_ready, rnd_ready, out_valid;
    logic [D*W-1:0] ina = '0;
    logic [D*W-1:0] inb = '0;
    logic [D*W-1:0] out;
    logic [RW-1:0]  rnd = '0;
`ifdef MSKAND_HPC2_RNDCNT_EN
    logic [31:0]    rnd_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_pop = 0;
    int base;
    int nacc;
    logic took;
    logic [W-1:0] cur_a = '0;
    logic [W-1:0] cur_b = '0;
    logic [W-1:0] exp_q[$];

    logic [W-1:0] va [6] = '{8'hA5, 8'hFF, 8'h00, 8'h55, 8'hF0, 8'hFF};
    logic [W-1:0] vb [6] = '{8'h3C, 8'hFF, 8'hFF, 8'hAA, 8'h0F, 8'h81};
    logic [W-1:0] sa [4] = '{8'h12, 8'hEE, 8'h7F, 8'h01};
    logic [W-1:0] sb [4] = '{8'hF3, 8'h6D, 8'hC8, 8'h10};

    always #5 clk = ~clk;

    mskand_hpc2_pipe #(.d(D), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ina       (ina),
        .inb       (inb),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef MSKAND_HPC2_RNDCNT_EN
        ,
        .rnd_cnt   (rnd_cnt)
`endif
    );

    function automatic logic [W-1:0] unmask(input logic [D*W-1:0] x);
        return x[W-1:0] ^ x[2*W-1:W] ^ x[3*W-1:2*W];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s0, s1, t0, t1;
        s0 = 8'($urandom);
        s1 = 8'($urandom);
        t0 = 8'($urandom);
        t1 = 8'($urandom);
        ina = {a ^ s0 ^ s1, s1, s0};
        inb = {b ^ t0 ^ t1, t1, t0};
        rnd = RW'($urandom);
        cur_a = a;
        cur_b = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every delivered result with the oldest expected one, then log new accepts.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check("result", 32'(unmask(out)), 32'(exp_q.pop_front()));
                n_pop++;
            end
        end
        if (in_valid && rnd_valid && in_ready) begin
            exp_q.push_back(cur_a & cur_b);
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rnd_ready_idle", 32'(rnd_ready), 32'd0);
        in_valid = 1'b1;
        #1;
        check("rst_rnd_ready_follows", 32'(rnd_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
`ifdef MSKAND_HPC2_RNDCNT_EN
        check("rnd_cnt_reset", rnd_cnt, 32'd0);
`endif

        // Single op: latency of exactly two cycles, rnd_ready for one cycle
        drive_op(8'hA5, 8'h3C);
        in_valid = 1'b1;
        rnd_valid = 1'b1;
        #1;
        check("lat_rnd_ready_on", 32'(rnd_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        #1;
        check("lat_rnd_ready_off", 32'(rnd_ready), 32'd0);
        check("lat_cycle1", 32'(out_valid), 32'd0);
        tick();
        check("lat_cycle2", 32'(out_valid), 32'd1);
        tick();
        check("lat_cycle3", 32'(out_valid), 32'd0);
        check("lat_count", n_pop, 1);

        // Back-to-back stream: directed corner vectors then random operands
        base = n_pop;
        in_valid = 1'b1;
        rnd_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if (n < 6) drive_op(va[n], vb[n]);
            else drive_op(8'($urandom), 8'($urandom));
            #1;
            check("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        repeat (3) tick();
        check("stream_count", n_pop - base, 1000);

        // Stall: three ops offered during five blocked cycles, only two fit
        base = n_pop;
        out_ready = 1'b0;
        in_valid = 1'b1;
        rnd_valid = 1'b1;
        nacc = 0;
        drive_op(sa[0], sb[0]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = in_ready;
            tick();
            if (took && nacc < 3) begin
                nacc++;
                drive_op(sa[nacc], sb[nacc]);
            end
        end
        check("stall_accepts", nacc, 2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_rnd_ready", 32'(rnd_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_no_output", n_pop - base, 0);
        out_ready = 1'b1;
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        repeat (4) tick();
        check("stall_drain_count", n_pop - base, 2);

        // rnd_valid toggling: accept only while fresh randomness is present
        base = n_pop;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_op(va[c+1], vb[c]);
            rnd_valid = (c % 2 == 0);
            #1;
            check("tog_rnd_ready", 32'(rnd_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        repeat (3) tick();
        check("tog_count", n_pop - base, 2);

        // Reset with both stages full: in-flight ops vanish without an output pulse
        base = n_pop;
        out_ready = 1'b0;
        in_valid = 1'b1;
        rnd_valid = 1'b1;
        drive_op(8'h0F, 8'hFF);
        tick();
        drive_op(8'hF0, 8'hFF);
        tick();
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (4) tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_no_output", n_pop - base, 0);

`ifdef MSKAND_HPC2_RNDCNT_EN
        check("rnd_cnt_after_rst", rnd_cnt, 32'd0);
        in_valid = 1'b1;
        rnd_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            drive_op(8'($urandom), 8'($urandom));
            tick();
        end
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        repeat (3) tick();
        check("rnd_cnt_10ops", rnd_cnt, 32'd240);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
